// File: rtl/branch_target_predictor_if.sv
// Fetch/execute bus of the branch target predictor.
// master = core pipeline, slave = predictor.
interface branch_target_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] lookup_pc_i;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            upd_en_i;
    logic            upd_is_jump_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] upd_target_i;
    logic            upd_pred_taken_i;
    logic [XLEN-1:0] upd_pred_target_i;
    logic            mispredict_o;
    logic [XLEN-1:0] correct_pc_o;

    modport master (
        output lookup_pc_i,
        output upd_en_i,
        output upd_is_jump_i,
        output upd_pc_i,
        output upd_taken_i,
        output upd_target_i,
        output upd_pred_taken_i,
        output upd_pred_target_i,
        input  pred_taken_o,
        input  pred_target_o,
        input  mispredict_o,
        input  correct_pc_o
    );

    modport slave (
        input  lookup_pc_i,
        input  upd_en_i,
        input  upd_is_jump_i,
        input  upd_pc_i,
        input  upd_taken_i,
        input  upd_target_i,
        input  upd_pred_taken_i,
        input  upd_pred_target_i,
        output pred_taken_o,
        output pred_target_o,
        output mispredict_o,
        output correct_pc_o
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Define BP_STATS_EN to add lookup/mispredict/allocation counters.
module branch_target_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input logic clk,
    input logic rst,
    branch_target_predictor_if.slave bus
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_lookups_o,
    output logic [31:0] stat_mispred_o,
    output logic [31:0] stat_alloc_o
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic             l_taken;

    assign l_idx   = bus.lookup_pc_i[IDX_W+1:2];
    assign l_tag   = bus.lookup_pc_i[XLEN-1:IDX_W+2];
    assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign l_taken = l_hit && ctr_q[l_idx][1];

    assign bus.pred_taken_o  = l_taken;
    assign bus.pred_target_o = l_taken ? target_q[l_idx] : '0;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^bus.lookup_pc_i[1:0];

    logic mis_dir;
    logic mis_tgt;

    assign mis_dir = bus.upd_pred_taken_i != bus.upd_taken_i;
    assign mis_tgt = bus.upd_taken_i &&
                     (bus.upd_pred_target_i != bus.upd_target_i);

    assign bus.mispredict_o = bus.upd_en_i && (mis_dir || mis_tgt);

    always_comb begin
        bus.correct_pc_o = '0;
        if (bus.upd_en_i) begin
            bus.correct_pc_o = bus.upd_taken_i ? bus.upd_target_i
                                               : bus.upd_pc_i + FOUR;
        end
    end

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_alloc;
    logic             u_tgt_we;
    logic             u_ctr_we;
    logic [1:0]       u_ctr;
    logic [1:0]       ctr_d;

    assign u_idx = bus.upd_pc_i[IDX_W+1:2];
    assign u_tag = bus.upd_pc_i[XLEN-1:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_ctr = ctr_q[u_idx];

    assign u_alloc  = bus.upd_en_i && !u_hit && bus.upd_taken_i;
    assign u_ctr_we = bus.upd_en_i && (u_hit || bus.upd_taken_i);
    assign u_tgt_we = bus.upd_en_i &&
                      (bus.upd_taken_i || (u_hit && bus.upd_is_jump_i));

    always_comb begin
        ctr_d = u_ctr;
        if (bus.upd_is_jump_i) begin
            ctr_d = 2'b11;
        end else if (!u_hit) begin
            ctr_d = 2'b10;
        end else if (bus.upd_taken_i) begin
            ctr_d = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
        end else begin
            ctr_d = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
        end
    end

    // Payload writes while reset is low are harmless: valid stays clear.
    always_ff @(posedge clk) begin
        if (u_tgt_we) target_q[u_idx] <= bus.upd_target_i;
        if (u_alloc)  tag_q[u_idx]    <= u_tag;
        if (u_ctr_we) ctr_q[u_idx]    <= ctr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (u_alloc) begin
            valid_q[u_idx] <= 1'b1;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] lookups_q;
    logic [31:0] mispred_q;
    logic [31:0] alloc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lookups_q <= '0;
            mispred_q <= '0;
            alloc_q   <= '0;
        end else begin
            if (bus.upd_en_i)     lookups_q <= lookups_q + 32'd1;
            if (bus.mispredict_o) mispred_q <= mispred_q + 32'd1;
            if (u_alloc)          alloc_q   <= alloc_q + 32'd1;
        end
    end

    assign stat_lookups_o = lookups_q;
    assign stat_mispred_o = mispred_q;
    assign stat_alloc_o   = alloc_q;
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed table-driven bench for branch_target_predictor.
module tb_branch_target_predictor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_target_predictor_if #(.XLEN(32)) bif ();

`ifdef BP_STATS_EN
    logic [31:0] st_lk;
    logic [31:0] st_mp;
    logic [31:0] st_al;
`endif

    branch_target_predictor #(.XLEN(32), .ENTRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
`ifdef BP_STATS_EN
        ,
        .stat_lookups_o (st_lk),
        .stat_mispred_o (st_mp),
        .stat_alloc_o   (st_al)
`endif
    );

    typedef struct {
        bit          en;
        bit          jmp;
        bit          tk;
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          ptk;
        logic [31:0] ptgt;
        logic [31:0] lpc;
        bit          e_ptk;
        logic [31:0] e_ptgt;
        bit          e_mis;
        logic [31:0] e_cpc;
        bit          alloc;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;
    int   n_lk = 0;
    int   n_mp = 0;
    int   n_al = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bif.upd_en_i          = v.en;
        bif.upd_is_jump_i     = v.jmp;
        bif.upd_taken_i       = v.tk;
        bif.upd_pc_i          = v.pc;
        bif.upd_target_i      = v.tgt;
        bif.upd_pred_taken_i  = v.ptk;
        bif.upd_pred_target_i = v.ptgt;
        bif.lookup_pc_i       = v.lpc;
    endtask

    task automatic add(input bit en, input bit jmp, input bit tk,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input bit ptk, input logic [31:0] ptgt,
                       input logic [31:0] lpc, input bit e_ptk,
                       input logic [31:0] e_ptgt, input bit e_mis,
                       input logic [31:0] e_cpc, input bit alloc);
        vec_t v;
        v = '{en, jmp, tk, pc, tgt, ptk, ptgt, lpc,
              e_ptk, e_ptgt, e_mis, e_cpc, alloc};
        vq.push_back(v);
    endtask

    initial begin
        vec_t v;
        // en jmp tk pc tgt ptk ptgt lpc | ptk ptgt mis cpc alloc
        add(0,0,0,'h0,'h0,0,'h0,'h40, 0,'h0,0,'h0,0);
        add(1,0,1,'h40,'h20,0,'h0,'h40, 0,'h0,1,'h20,1);
        add(0,0,0,'h0,'h0,0,'h0,'h40, 1,'h20,0,'h0,0);
        add(1,0,0,'h40,'h0,1,'h20,'h40, 1,'h20,1,'h44,0);
        add(0,0,0,'h0,'h0,0,'h0,'h40, 0,'h0,0,'h0,0);
        add(1,0,1,'h40,'h20,0,'h0,'h40, 0,'h0,1,'h20,0);
        add(1,0,1,'h40,'h20,1,'h20,'h40, 1,'h20,0,'h20,0);
        add(1,0,1,'h40,'h20,1,'h20,'h40, 1,'h20,0,'h20,0);
        add(1,0,1,'h40,'h20,1,'h20,'h40, 1,'h20,0,'h20,0);
        add(1,0,0,'h40,'h0,1,'h20,'h40, 1,'h20,1,'h44,0);
        add(0,0,0,'h0,'h0,0,'h0,'h40, 1,'h20,0,'h0,0);
        add(1,0,0,'h40,'h0,1,'h20,'h40, 1,'h20,1,'h44,0);
        add(1,0,0,'h40,'h0,0,'h0,'h40, 0,'h0,0,'h44,0);
        add(1,0,0,'h40,'h0,0,'h0,'h40, 0,'h0,0,'h44,0);
        add(1,0,1,'h40,'h20,0,'h0,'h40, 0,'h0,1,'h20,0);
        add(0,0,0,'h0,'h0,0,'h0,'h40, 0,'h0,0,'h0,0);
        add(1,1,1,'h80,'h300,0,'h0,'h40, 0,'h0,1,'h300,1);
        add(0,0,0,'h0,'h0,0,'h0,'h40, 0,'h0,0,'h0,0);
        add(0,0,0,'h0,'h0,0,'h0,'h80, 1,'h300,0,'h0,0);
        add(1,1,1,'h80,'h340,1,'h300,'h80, 1,'h300,1,'h340,0);
        add(0,0,0,'h0,'h0,0,'h0,'h80, 1,'h340,0,'h0,0);
        add(0,0,0,'h0,'h0,0,'h0,'h84, 0,'h0,0,'h0,0);
        add(1,0,0,'h100,'h0,1,'h180,'h80, 1,'h340,1,'h104,0);
        add(1,0,1,'h100,'h200,1,'h180,'h84, 0,'h0,1,'h200,1);
        add(0,0,0,'h0,'h0,0,'h0,'h100, 1,'h200,0,'h0,0);
        add(0,0,0,'h0,'h0,0,'h0,'h80, 0,'h0,0,'h0,0);
        add(1,0,0,'hFFFF_FFFC,'h0,0,'h0,'h100, 1,'h200,0,'h0,0);
        add(0,1,1,'h40,'h99C,0,'h0,'h100, 1,'h200,0,'h0,0);

        v = vq[0];
        drive(v);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            check($sformatf("v%0d pred_taken", i),
                  32'(bif.pred_taken_o), 32'(vq[i].e_ptk));
            check($sformatf("v%0d pred_target", i),
                  bif.pred_target_o, vq[i].e_ptgt);
            check($sformatf("v%0d mispredict", i),
                  32'(bif.mispredict_o), 32'(vq[i].e_mis));
            check($sformatf("v%0d correct_pc", i),
                  bif.correct_pc_o, vq[i].e_cpc);
            n_lk += int'(vq[i].en);
            n_mp += int'(vq[i].e_mis);
            n_al += int'(vq[i].alloc);
        end

        @(negedge clk);
`ifdef BP_STATS_EN
        check("stat_lookups", st_lk, 32'(n_lk));
        check("stat_mispred", st_mp, 32'(n_mp));
        check("stat_alloc", st_al, 32'(n_al));
`endif

        // Reset mid-run with an allocating jump pending at pc 0x84.
        v = '{1, 1, 1, 'h84, 'h500, 0, 'h0, 'h100,
              0, 'h0, 0, 'h0, 0};
        drive(v);
        #1;
        check("pre-rst hit", 32'(bif.pred_taken_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst async clear", 32'(bif.pred_taken_o), 32'd0);
        check("rst tgt clear", bif.pred_target_o, 32'h0);
        check("rst mispredict", 32'(bif.mispredict_o), 32'd1);
        check("rst correct_pc", bif.correct_pc_o, 32'h500);
        @(negedge clk);
        rst = 1'b1;
        bif.upd_en_i = 1'b0;
        bif.lookup_pc_i = 32'h84;
        #1;
        check("post-rst 0x84", 32'(bif.pred_taken_o), 32'd0);
        check("post-rst upd off", 32'(bif.mispredict_o), 32'd0);
        bif.lookup_pc_i = 32'h100;
        #1;
        check("post-rst 0x100", 32'(bif.pred_taken_o), 32'd0);
        @(negedge clk);
        bif.lookup_pc_i = 32'h84;
        #1;
        check("later 0x84", 32'(bif.pred_taken_o), 32'd0);
`ifdef BP_STATS_EN
        check("rst stat_lookups", st_lk, 32'd0);
        check("rst stat_mispred", st_mp, 32'd0);
        check("rst stat_alloc", st_al, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
